sb_pipelined_xbar: RTL and testbench

- Successor to the single-bus switch box used in the routing fabric.
- Each output side/track has its own independent source mux, so N->W and E->S on the same track can coexist without contention.
- Configuration is double-buffered: a shadow scan chain with a bit-counting load state machine feeds an active register, and routing stays live while a new configuration shifts in.
- Each output can optionally be registered to break long combinational routing paths.

---
 rtl/sb_pipelined_xbar_if.sv | 31 +++
 rtl/sb_pipelined_xbar.sv | 112 +++++++++++
 tb/tb_sb_pipelined_xbar.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_pipelined_xbar_if.sv
// Side data buses and serial configuration port of the switch box.
// No flow control: data is level-based and the scan chain shifts whenever enabled.
interface sb_pipelined_xbar_if #(
  parameter int TRACKS = 8
);
  logic [TRACKS-1:0] north_in;
  logic [TRACKS-1:0] east_in;
  logic [TRACKS-1:0] south_in;
  logic [TRACKS-1:0] west_in;
  logic [TRACKS-1:0] north_out;
  logic [TRACKS-1:0] east_out;
  logic [TRACKS-1:0] south_out;
  logic [TRACKS-1:0] west_out;
  logic              cfg_in;
  logic              cfg_en;
  logic              cfg_commit;
  logic              cfg_out;
  logic              cfg_ready;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output north_in, east_in, south_in, west_in, cfg_in, cfg_en, cfg_commit,
    input  north_out, east_out, south_out, west_out, cfg_out, cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  north_in, east_in, south_in, west_in, cfg_in, cfg_en, cfg_commit,
    output north_out, east_out, south_out, west_out, cfg_out, cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/sb_pipelined_xbar.sv
// Per-output-mux switch box with double-buffered scan configuration.
// Latency 0 (combinational) or 1 (registered) per output; no backpressure, config shifts alongside live routing.
module sb_pipelined_xbar #(
  parameter int TRACKS = 8
) (
  input logic                 clk,
  input logic                 rst,
  sb_pipelined_xbar_if.slave  bus
);
  localparam int FIELD_W  = 4;
  localparam int SIDES    = 4;
  localparam int CFG_BITS = TRACKS * SIDES * FIELD_W;
  localparam int CW       = $clog2(CFG_BITS + 2);

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    FULL,
    OVER
  } load_t;

  logic [CFG_BITS-1:0]       shadow;
  logic [CFG_BITS-1:0]       active;
  logic [CW-1:0]             cnt;
  load_t                     load_state;
  logic                      done_q;
  logic                      err_q;
  logic [SIDES*TRACKS-1:0]   ins;
  logic [SIDES*TRACKS-1:0]   mux;
  logic [SIDES*TRACKS-1:0]   pipe;
  logic [SIDES*TRACKS-1:0]   outs;

  // Side s, track t lives at bit s*TRACKS+t of the flat vectors.
  assign ins = {bus.west_in, bus.south_in, bus.east_in, bus.north_in};

  // Load state is a pure decode of the saturating bit counter.
  always_comb begin
    if (cnt == '0) begin
      load_state = IDLE;
    end else if (cnt < CW'(CFG_BITS)) begin
      load_state = LOADING;
    end else if (cnt == CW'(CFG_BITS)) begin
      load_state = FULL;
    end else begin
      load_state = OVER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.cfg_commit) begin
        cnt <= '0;
        if (load_state == FULL) begin
          active <= shadow;
          done_q <= 1'b1;
          err_q  <= 1'b0;
        end else begin
          err_q  <= 1'b1;
        end
      end else if (bus.cfg_en) begin
        shadow <= {shadow[CFG_BITS-2:0], bus.cfg_in};
        if (load_state != OVER) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // The pipeline flop tracks the mux every cycle, independent of its reg bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe <= mux;
    end
  end

  for (genvar o = 0; o < SIDES; o++) begin : gen_side
    for (genvar t = 0; t < TRACKS; t++) begin : gen_track
      localparam int BASE = ((t * SIDES) + o) * FIELD_W;
      localparam int BIT  = o * TRACKS + t;
      localparam int P1   = ((o + 1) % SIDES) * TRACKS + t;
      localparam int P2   = ((o + 2) % SIDES) * TRACKS + t;
      localparam int P3   = ((o + 3) % SIDES) * TRACKS + t;
      localparam int PH   = ((o + 2) % SIDES) * TRACKS + ((t + 1) % TRACKS);

      logic [FIELD_W-1:0] fld;

      // fld = {reg, en, src[1:0]}
      assign fld       = active[BASE +: FIELD_W];
      assign mux[BIT]  = fld[1] ? (fld[0] ? ins[PH] : ins[P3])
                                : (fld[0] ? ins[P2] : ins[P1]);
      assign outs[BIT] = fld[2] & (fld[3] ? pipe[BIT] : mux[BIT]);
    end
  end

  assign bus.north_out = outs[0*TRACKS +: TRACKS];
  assign bus.east_out  = outs[1*TRACKS +: TRACKS];
  assign bus.south_out = outs[2*TRACKS +: TRACKS];
  assign bus.west_out  = outs[3*TRACKS +: TRACKS];
  assign bus.cfg_out   = shadow[CFG_BITS-1];
  assign bus.cfg_ready = (load_state == FULL);
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_sb_pipelined_xbar.sv
// Randomized bench for sb_pipelined_xbar with a behavioural reference model and a per-cycle compare.
module tb_sb_pipelined_xbar;
  localparam int T  = 4;
  localparam int CB = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sb_pipelined_xbar_if #(.TRACKS(T)) bus();
  sb_pipelined_xbar #(.TRACKS(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Reference model state
  logic [CB-1:0] m_act;
  logic [CB-1:0] m_sh;
  int            m_cnt;
  bit            m_done;
  bit            m_err;
  logic [T-1:0]  m_pipe [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_bit(input int s, input int t);
    case (s)
      0:       return bus.north_in[t];
      1:       return bus.east_in[t];
      2:       return bus.south_in[t];
      default: return bus.west_in[t];
    endcase
  endfunction

  // Value selected for output side o, track t under the model's active config.
  function automatic logic src_val(input int o, input int t);
    logic [3:0] f;
    int src;
    f   = m_act[((t*4)+o)*4 +: 4];
    src = int'(f[1:0]);
    if (src < 3) return in_bit((o + src + 1) % 4, t);
    return in_bit((o + 2) % 4, (t + 1) % T);
  endfunction

  function automatic logic [T-1:0] exp_out(input int o);
    logic [T-1:0] r;
    logic [3:0] f;
    r = '0;
    for (int t = 0; t < T; t++) begin
      f = m_act[((t*4)+o)*4 +: 4];
      if (f[2]) r[t] = f[3] ? m_pipe[o][t] : src_val(o, t);
    end
    return r;
  endfunction

  function automatic logic [T-1:0] dut_out(input int o);
    case (o)
      0:       return bus.north_out;
      1:       return bus.east_out;
      2:       return bus.south_out;
      default: return bus.west_out;
    endcase
  endfunction

  function automatic logic [CB-1:0] fset(input logic [CB-1:0] c, input int t, input int o, input logic [3:0] f);
    logic [CB-1:0] r;
    r = c;
    r[((t*4)+o)*4 +: 4] = f;
    return r;
  endfunction

  // Model update for one rising edge, using the inputs the DUT samples there.
  task automatic model_step();
    logic [T-1:0] nxt [4];
    for (int o = 0; o < 4; o++)
      for (int t = 0; t < T; t++)
        nxt[o][t] = src_val(o, t);
    if (rst) begin
      m_act = '0; m_sh = '0; m_cnt = 0; m_done = 0; m_err = 0;
      for (int o = 0; o < 4; o++) m_pipe[o] = '0;
    end else begin
      for (int o = 0; o < 4; o++) m_pipe[o] = nxt[o];
      m_done = 0;
      if (bus.cfg_commit) begin
        if (m_cnt == CB) begin
          m_act = m_sh; m_done = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
        m_cnt = 0;
      end else if (bus.cfg_en) begin
        m_sh = {m_sh[CB-2:0], bus.cfg_in};
        if (m_cnt < CB + 1) m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int o = 0; o < 4; o++)
        check($sformatf("out_side%0d", o), 64'(dut_out(o)), 64'(exp_out(o)));
      check("cfg_out",   64'(bus.cfg_out),   64'(m_sh[CB-1]));
      check("cfg_ready", 64'(bus.cfg_ready), 64'(m_cnt == CB));
      check("cfg_done",  64'(bus.cfg_done),  64'(m_done));
      check("cfg_err",   64'(bus.cfg_err),   64'(m_err));
    end
  end

  task automatic rnd_in();
    bus.north_in = 4'($urandom);
    bus.east_in  = 4'($urandom);
    bus.south_in = 4'($urandom);
    bus.west_in  = 4'($urandom);
  endtask

  // Shift v[n-1] first down to v[0] last.
  task automatic shift_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = v[i];
      rnd_in();
      tick();
    end
    bus.cfg_en = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  logic [CB-1:0]  cfg_a, cfg_b, cfg_c, cfg_d;
  logic [127:0]   rv;
  bit             ovf_bits [65];

  initial begin
    rst = 1'b1;
    bus.cfg_in = 1'b0; bus.cfg_en = 1'b0; bus.cfg_commit = 1'b0;
    m_act = '0; m_sh = '0; m_cnt = 0; m_done = 0; m_err = 0;
    for (int o = 0; o < 4; o++) m_pipe[o] = '0;

    // Reset with random inputs
    rnd_in();
    tick();
    chk_on = 1'b1;
    rnd_in();
    tick();
    rst = 1'b0;
    rnd_in();
    #1;
    check("rst_outs", 64'({bus.north_out, bus.east_out, bus.south_out, bus.west_out}), 64'd0);
    check("rst_cfg",  64'({bus.cfg_out, bus.cfg_ready, bus.cfg_done, bus.cfg_err}), 64'd0);
    tick();

    // Independent routing: W[2] from E (comb), S[2] from W (comb)
    cfg_a = fset(fset('0, 2, 3, 4'b0101), 2, 2, 4'b0100);
    shift_bits({64'd0, cfg_a}, 64);
    commit();
    bus.east_in = 4'b0100; bus.west_in = 4'b0100;
    bus.north_in = 4'($urandom); bus.south_in = 4'($urandom);
    #1;
    check("indep_west",  64'(bus.west_out),  64'h4);
    check("indep_south", 64'(bus.south_out), 64'h4);
    check("indep_ne",    64'({bus.north_out, bus.east_out}), 64'h0);
    check("indep_done",  64'(bus.cfg_done),  64'h1);
    tick();
    check("indep_done_once", 64'(bus.cfg_done), 64'h0);

    // Registered track hop: N[3] <= flop of S[0]
    cfg_b = fset(cfg_a, 3, 0, 4'b1111);
    shift_bits({64'd0, cfg_b}, 64);
    commit();
    bus.south_in = 4'b0000;
    tick();
    tick();
    bus.south_in = 4'b0001;
    #1;
    check("hop_same_cycle", 64'(bus.north_out), 64'h0);
    tick();
    check("hop_next_cycle", 64'(bus.north_out), 64'h8);

    // Bad count: 63 bits then commit
    rv = {$urandom, $urandom, $urandom, $urandom};
    shift_bits(rv, 63);
    commit();
    check("bad_err",  64'(bus.cfg_err),  64'h1);
    check("bad_done", 64'(bus.cfg_done), 64'h0);
    bus.east_in = 4'b0100; bus.west_in = 4'b0000;
    #1;
    check("bad_keep_route", 64'(bus.west_out), 64'h4);
    cfg_c = '0;
    for (int t = 0; t < T; t++) cfg_c = fset(cfg_c, t, 1, 4'b0110);
    shift_bits({64'd0, cfg_c}, 64);
    commit();
    check("good_err",  64'(bus.cfg_err),  64'h0);
    check("good_done", 64'(bus.cfg_done), 64'h1);

    // Overflow with live N->E routing
    for (int k = 0; k < 65; k++) begin
      ovf_bits[k] = 1'($urandom);
      bus.cfg_en = 1'b1;
      bus.cfg_in = ovf_bits[k];
      rnd_in();
      #1;
      check("ovf_live_route", 64'(bus.east_out), 64'(bus.north_in));
      tick();
      check("ovf_ready", 64'(bus.cfg_ready), 64'(k + 1 == 64));
      if (k + 1 >= 64) check("ovf_cfg_out", 64'(bus.cfg_out), 64'(ovf_bits[k + 1 - 64]));
    end
    bus.cfg_en = 1'b0;
    commit();
    check("ovf_err",  64'(bus.cfg_err),  64'h1);
    check("ovf_done", 64'(bus.cfg_done), 64'h0);
    bus.north_in = 4'b1010;
    #1;
    check("ovf_keep_route", 64'(bus.east_out), 64'ha);

    // Reset coincident with commit, then mid-shift
    cfg_d = {$urandom, $urandom} | 64'h4444_4444_4444_4444;
    shift_bits({64'd0, cfg_d}, 64);
    bus.cfg_commit = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cfg_commit = 1'b0;
    rnd_in();
    #1;
    check("rstc_outs", 64'({bus.north_out, bus.east_out, bus.south_out, bus.west_out}), 64'd0);
    check("rstc_done", 64'(bus.cfg_done), 64'h0);
    shift_bits({$urandom, $urandom, $urandom, $urandom}, 30);
    bus.cfg_en = 1'b1;
    bus.cfg_in = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cfg_en = 1'b0;
    check("rsts_ready", 64'({bus.cfg_ready, bus.cfg_out}), 64'h0);
    shift_bits({64'd0, cfg_c}, 64);
    commit();
    check("rsts_fresh_done", 64'(bus.cfg_done), 64'h1);

    // Random configs, counts, resets and traffic
    for (int it = 0; it < 20; it++) begin
      int n;
      n = ($urandom_range(3) == 0) ? 62 + int'($urandom_range(4)) : 64;
      shift_bits({$urandom, $urandom, $urandom, $urandom}, n);
      for (int c = 0; c < int'($urandom_range(3)); c++) begin
        rnd_in();
        tick();
      end
      if ($urandom_range(9) == 0) rst = 1'b1;
      commit();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
        rnd_in();
        tick();
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
